// File: rtl/dfr_reservoir_pipe.sv
// dfr_reservoir_pipe -- delay-feedback reservoir with a parametrised chain
// of virtual nodes. Each accepted step forms sum = din + (tail << FB_LSHIFT) >> eta,
// presents sum as an address to an external activation memory, waits
// ACT_LATENCY clocks for the read data and shifts that word into node 0.
//
// Optional build macro: DFR_RESERVOIR_SAT_EN
//   defined   : sum is DATA_WIDTH+1 bits; act_addr saturates to all ones
//               once sum >= 2**ADDR_WIDTH
//   undefined : act_addr is the low ADDR_WIDTH bits of the wrapped sum
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous clear of nodes, counters and state
//   in_valid/in_ready   input sample handshake (din, eta)
//   din, eta            masked sample and feedback attenuation shift
//   act_addr/act_data   activation memory address (registered) / read data
//   load_node, node_sel, load_node_din   node load port (IDLE only)
//   node_dout           combinational readback of node node_sel
//   dout                tail node
//   step_done           one-cycle pulse after each shift
//   busy                high while a step is in flight
//   step_count          saturating count of completed steps
//   o_dbg_state         current FSM state (0 IDLE, 1 WAIT, 2 SHIFT)
//
// Handshake: a sample is taken on a rising edge where in_valid and in_ready
// are both high. in_ready is high only in IDLE with no node load requested;
// din and eta are sampled on that edge and need not be held afterwards.
module dfr_reservoir_pipe #(
  parameter int NUM_VIRTUAL_NODES = 100,
  parameter int DATA_WIDTH        = 32,
  parameter int NODE_DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH        = 16,
  parameter int ACT_LATENCY       = 2,
  parameter int FB_LSHIFT         = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                din,
  input  logic [3:0]                           eta,
  output logic [ADDR_WIDTH-1:0]                act_addr,
  input  logic [NODE_DATA_WIDTH-1:0]           act_data,
  input  logic                                 load_node,
  input  logic [$clog2(NUM_VIRTUAL_NODES)-1:0] node_sel,
  input  logic [NODE_DATA_WIDTH-1:0]           load_node_din,
  output logic [NODE_DATA_WIDTH-1:0]           node_dout,
  output logic [NODE_DATA_WIDTH-1:0]           dout,
  output logic                                 step_done,
  output logic                                 busy,
  output logic [15:0]                          step_count,
  output logic [1:0]                           o_dbg_state
);

  localparam int SEL_W = $clog2(NUM_VIRTUAL_NODES);
  localparam int FBW   = NODE_DATA_WIDTH + FB_LSHIFT;
  localparam int CNT_W = (ACT_LATENCY > 1) ? $clog2(ACT_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACT_LATENCY - 1);
  // One extra bit so the range check is not constant when N is a power of two.
  localparam logic [SEL_W:0] SEL_LIM = NUM_VIRTUAL_NODES[SEL_W:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [NODE_DATA_WIDTH-1:0]  r_nodes [NUM_VIRTUAL_NODES];
  logic [ADDR_WIDTH-1:0]       r_act_addr;
  logic                        r_step_done;
  logic [15:0]                 r_step_count;

  logic                        w_sel_ok;
  logic [FBW-1:0]              w_fb_wide;
  logic [DATA_WIDTH-1:0]       w_fb;
  logic [ADDR_WIDTH-1:0]       w_addr;

  assign w_sel_ok  = ({1'b0, node_sel} < SEL_LIM);
  // Tail is scaled up first so that small eta values keep fractional bits.
  assign w_fb_wide = (FBW'(r_nodes[NUM_VIRTUAL_NODES-1]) << FB_LSHIFT) >> eta;
  assign w_fb      = DATA_WIDTH'(w_fb_wide);

`ifdef DFR_RESERVOIR_SAT_EN
  logic [DATA_WIDTH:0]         w_sum;
  assign w_sum  = {1'b0, din} + {1'b0, w_fb};
  assign w_addr = (|w_sum[DATA_WIDTH:ADDR_WIDTH]) ? '1 : w_sum[ADDR_WIDTH-1:0];
`else
  // Sum wraps modulo 2**DATA_WIDTH, then only the low address bits are kept.
  assign w_addr = ADDR_WIDTH'(din + w_fb);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_act_addr   <= '0;
      r_step_done  <= 1'b0;
      r_step_count <= '0;
      for (int k = 0; k < NUM_VIRTUAL_NODES; k++) r_nodes[k] <= '0;
    end else if (clear) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_act_addr   <= '0;
      r_step_done  <= 1'b0;
      r_step_count <= '0;
      for (int k = 0; k < NUM_VIRTUAL_NODES; k++) r_nodes[k] <= '0;
    end else begin
      r_step_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A load request wins over an input sample in the same cycle.
          if (load_node) begin
            if (w_sel_ok) r_nodes[node_sel] <= load_node_din;
          end else if (in_valid) begin
            r_act_addr <= w_addr;
            r_cnt      <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_LAST) r_state <= S_SHIFT;
          else                   r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_SHIFT: begin
          r_nodes[0] <= act_data;
          for (int k = 1; k < NUM_VIRTUAL_NODES; k++) r_nodes[k] <= r_nodes[k-1];
          r_step_done <= 1'b1;
          if (r_step_count != 16'hFFFF) r_step_count <= r_step_count + 16'd1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE) & ~load_node;
  assign busy        = (r_state != S_IDLE);
  assign act_addr    = r_act_addr;
  assign step_done   = r_step_done;
  assign step_count  = r_step_count;
  assign dout        = r_nodes[NUM_VIRTUAL_NODES-1];
  assign node_dout   = w_sel_ok ? r_nodes[node_sel] : '0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dfr_reservoir_pipe.sv
// tb_dfr_reservoir_pipe -- directed bench for dfr_reservoir_pipe with four
// nodes and a two-cycle activation memory that returns addr[11:0]. A second
// six-node instance covers out-of-range node_sel handling.
module tb_dfr_reservoir_pipe;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NW = 12;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clear, in_valid, in_ready, load_node, step_done, busy;
  logic [DW-1:0] din;
  logic [3:0]    eta;
  logic [AW-1:0] act_addr;
  logic [NW-1:0] act_data, load_node_din, node_dout, dout;
  logic [1:0]    node_sel, dbg_state;
  logic [15:0]   step_count;

  dfr_reservoir_pipe #(
    .NUM_VIRTUAL_NODES(N), .DATA_WIDTH(DW), .NODE_DATA_WIDTH(NW),
    .ADDR_WIDTH(AW), .ACT_LATENCY(2), .FB_LSHIFT(4)
  ) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .eta(eta), .act_addr(act_addr), .act_data(act_data),
    .load_node(load_node), .node_sel(node_sel), .load_node_din(load_node_din),
    .node_dout(node_dout), .dout(dout), .step_done(step_done), .busy(busy),
    .step_count(step_count), .o_dbg_state(dbg_state)
  );

  // Six-node instance: node_sel is 3 bits wide so indices 6 and 7 exist.
  logic          load6, rdy6, done6, busy6;
  logic [2:0]    sel6;
  logic [NW-1:0] ldin6, ndout6, dout6;
  logic [AW-1:0] addr6;
  logic [15:0]   cnt6;
  logic [1:0]    dbg6;

  dfr_reservoir_pipe #(
    .NUM_VIRTUAL_NODES(6), .DATA_WIDTH(DW), .NODE_DATA_WIDTH(NW),
    .ADDR_WIDTH(AW), .ACT_LATENCY(2), .FB_LSHIFT(4)
  ) u_dut6 (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(1'b0), .in_ready(rdy6),
    .din('0), .eta(4'd0), .act_addr(addr6), .act_data('0),
    .load_node(load6), .node_sel(sel6), .load_node_din(ldin6),
    .node_dout(ndout6), .dout(dout6), .step_done(done6), .busy(busy6),
    .step_count(cnt6), .o_dbg_state(dbg6)
  );

  // Activation memory model: two-cycle read latency, data = addr[11:0].
  logic [NW-1:0] mem_p1, mem_p2;
  always_ff @(posedge clk) begin
    mem_p1 <= act_addr[NW-1:0];
    mem_p2 <= mem_p1;
  end
  assign act_data = mem_p2;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [NW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [NW-1:0] v);
    load_node = 1'b1; node_sel = sel; load_node_din = v;
    tick();
    load_node = 1'b0;
  endtask

  task automatic rd_node(input logic [1:0] sel, output logic [NW-1:0] v);
    node_sel = sel;
    #1;
    v = node_dout;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (step_done !== 1'b1 && cycles < 12) begin
      tick();
      cycles++;
    end
  endtask

  typedef struct {
    logic [DW-1:0] din;
    logic [3:0]    eta;
    logic [NW-1:0] tail;
    logic [NW-1:0] n2;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t          vecs [7];
  logic [NW-1:0] b2b_din [4];
  logic [NW-1:0] v;
  int            c, acc, rdy, pulses;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- vector table (expected addresses worked out by hand) ----
    vecs[0] = '{32'h0000_0010, 4'd0,  12'h000, 12'h000, 16'h0010};
    vecs[1] = '{32'h0000_0005, 4'd2,  12'h0A0, 12'h123, 16'h0285};
    vecs[3] = '{32'h0000_0000, 4'd15, 12'hFFF, 12'h000, 16'h0001};
    vecs[5] = '{32'h0000_0100, 4'd1,  12'h001, 12'hABC, 16'h0108};
`ifdef DFR_RESERVOIR_SAT_EN
    vecs[2] = '{32'h0000_FFFF, 4'd0,  12'hFFF, 12'h007, 16'hFFFF};
    vecs[4] = '{32'h1234_0000, 4'd4,  12'h800, 12'h456, 16'hFFFF};
    vecs[6] = '{32'hFFFF_FFFF, 4'd12, 12'hFFF, 12'h0F0, 16'hFFFF};
`else
    vecs[2] = '{32'h0000_FFFF, 4'd0,  12'hFFF, 12'h007, 16'hFFEF};
    vecs[4] = '{32'h1234_0000, 4'd4,  12'h800, 12'h456, 16'h0800};
    vecs[6] = '{32'hFFFF_FFFF, 4'd12, 12'hFFF, 12'h0F0, 16'h000E};
`endif
    b2b_din[0] = 12'h111; b2b_din[1] = 12'h222; b2b_din[2] = 12'h3A5; b2b_din[3] = 12'h0FE;

    // ---- reset ----
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; din = '0; eta = '0;
    load_node = 1'b0; node_sel = '0; load_node_din = '0;
    load6 = 1'b0; sel6 = '0; ldin6 = '0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_act_addr", 32'(act_addr), 32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_step_done", 32'(step_done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();

    // ---- table-driven single steps ----
    for (int i = 0; i < 7; i++) begin
      do_clear();
      load(2'd3, vecs[i].tail);
      load(2'd2, vecs[i].n2);
      in_valid = 1'b1; din = vecs[i].din; eta = vecs[i].eta;
      tick();
      in_valid = 1'b0; din = $urandom; eta = 4'($urandom_range(0, 15));
      chk($sformatf("v%0d_act_addr", i), 32'(act_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd0);
      wait_done(c);
      chk($sformatf("v%0d_latency", i), 32'(c), 32'd3);
      rd_node(2'd0, v);
      chk($sformatf("v%0d_node0", i), 32'(v), 32'(vecs[i].addr[NW-1:0]));
      rd_node(2'd1, v);
      chk($sformatf("v%0d_node1", i), 32'(v), 32'd0);
      chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].n2));
      chk($sformatf("v%0d_step_count", i), 32'(step_count), 32'd1);
      chk($sformatf("v%0d_act_hold", i), 32'(act_addr), 32'(vecs[i].addr));
      tick();
      chk($sformatf("v%0d_done_pulse", i), 32'(step_done), 32'd0);
    end

    // ---- back-to-back samples with in_valid held high ----
    do_clear();
    exp_q.delete();
    acc = 0; rdy = 0; pulses = 0;
    eta = 4'd0;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (step_done === 1'b1) begin
        pulses++;
        rd_node(2'd0, v);
        if (exp_q.size() > 0) chk("b2b_node0", 32'(v), 32'(exp_q.pop_front()));
      end
      if (acc == 4) in_valid = 1'b0;
      else          din = 32'(b2b_din[acc]);
      if (cyc < 16 && in_ready === 1'b1) rdy++;
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(b2b_din[acc]);
        acc++;
      end
      tick();
    end
    chk("b2b_ready_cycles", 32'(rdy), 32'd4);
    chk("b2b_pulses", 32'(pulses), 32'd4);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("b2b_step_count", 32'(step_count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      rd_node(2'(k), v);
      chk($sformatf("b2b_node%0d", k), 32'(v), 32'(b2b_din[3-k]));
    end
    chk("b2b_dout", 32'(dout), 32'(b2b_din[0]));

    // ---- load during WAIT is ignored ----
    do_clear();
    in_valid = 1'b1; din = 32'h10; eta = 4'd0;
    tick();
    in_valid = 1'b0;
    load_node = 1'b1; node_sel = 2'd2; load_node_din = 12'hABC;
    tick();
    load_node = 1'b0;
    wait_done(c);
    chk("wload_latency", 32'(c), 32'd2);
    chk("wload_dout", 32'(dout), 32'd0);
    rd_node(2'd2, v);
    chk("wload_node2", 32'(v), 32'd0);
    rd_node(2'd0, v);
    chk("wload_node0", 32'(v), 32'h010);

    // ---- load with in_valid in IDLE: load wins, no accept ----
    do_clear();
    load_node = 1'b1; node_sel = 2'd1; load_node_din = 12'h5A5;
    in_valid = 1'b1; din = 32'h20;
    #1;
    chk("lv_in_ready", 32'(in_ready), 32'd0);
    tick();
    load_node = 1'b0; in_valid = 1'b0;
    chk("lv_busy", 32'(busy), 32'd0);
    chk("lv_act_addr", 32'(act_addr), 32'd0);
    rd_node(2'd1, v);
    chk("lv_node1", 32'(v), 32'h5A5);

    // ---- clear during WAIT ----
    do_clear();
    load(2'd0, 12'h111);
    in_valid = 1'b1; din = 32'h33;
    tick();
    in_valid = 1'b0;
    chk("clr_pre_state", 32'(dbg_state), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_state", 32'(dbg_state), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_act_addr", 32'(act_addr), 32'd0);
    rd_node(2'd0, v);
    chk("clr_node0", 32'(v), 32'd0);
    pulses = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (step_done === 1'b1) pulses++;
      tick();
    end
    chk("clr_no_done", 32'(pulses), 32'd0);
    chk("clr_step_count", 32'(step_count), 32'd0);

    // ---- reset with a shift pending ----
    load(2'd3, 12'h777);
    in_valid = 1'b1; din = 32'h44;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("rstm_pre_state", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    #1;
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_act_addr", 32'(act_addr), 32'd0);
    chk("rstm_dout", 32'(dout), 32'd0);
    chk("rstm_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("rstm_step_done", 32'(step_done), 32'd0);
    chk("rstm_step_count", 32'(step_count), 32'd0);
    rd_node(2'd0, v);
    chk("rstm_node0", 32'(v), 32'd0);

    // ---- out-of-range node_sel on the six-node instance ----
    load6 = 1'b1; sel6 = 3'd7; ldin6 = 12'hFFF;
    tick();
    load6 = 1'b0;
    chk("oor_dout7", 32'(ndout6), 32'd0);
    for (int k = 0; k < 6; k++) begin
      sel6 = 3'(k);
      #1;
      chk($sformatf("oor_node%0d", k), 32'(ndout6), 32'd0);
    end
    load6 = 1'b1; sel6 = 3'd5; ldin6 = 12'h3C3;
    tick();
    load6 = 1'b0;
    chk("oor_node5_load", 32'(ndout6), 32'h3C3);
    chk("oor_tail", 32'(dout6), 32'h3C3);

    // ---- report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
